load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 19 +
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit_timeout_counter.sv | 27 ++
 rtl/load_store_unit.sv | 107 ++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM encoding, default
// widths and the alignment rule for doubleword accesses.
package load_store_unit_pkg;

  localparam int WORD_DEFAULT    = 64;
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  // Doubleword accesses must sit on an 8-byte boundary.
  function automatic logic is_aligned(input logic [2:0] lsb);
    return lsb == 3'd0;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and its responder (slave).
// Handshake: master holds bus_req with stable we/addr/wdata until the responder
// pulses bus_ack for one cycle; bus_rdata is only meaningful while bus_ack is high.
interface load_store_unit_if #(
  parameter int WORD = 64
) ();
  logic            bus_req;
  logic            bus_we;
  logic [WORD-1:0] bus_addr;
  logic [WORD-1:0] bus_wdata;
  logic            bus_ack;
  logic [WORD-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit_timeout_counter.sv
// Counts BUSY cycles; expired goes high on the TIMEOUT-th cycle of an access
// and the count saturates there until the next clear.
module lsu_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one LDUR/STUR at a time from the pipeline, stalls it,
// runs a single bus transaction with a timeout, and reports result/error in DONE.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WORD    = WORD_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [WORD-1:0]       address,
  input  logic [WORD-1:0]       write_data,
  output logic [WORD-1:0]       read_data,
  output logic                  stall,
  output logic                  error,
  output lsu_state_t            state_dbg,
  load_store_unit_if.master     bus
);
  lsu_state_t      state, next_state;
  logic [WORD-1:0] addr_q, wdata_q, rdata_q;
  logic            we_q, is_read_q, error_q;
  logic            accept, legal, expired, bus_req_c;

  assign accept = (state == ST_IDLE) && (mem_read || mem_write);
  assign legal  = is_aligned(address[2:0]) && !(mem_read && mem_write);

  lsu_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept && legal),
    .enable  (state == ST_BUSY),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = legal ? ST_BUSY : ST_DONE;
      ST_BUSY: if (bus.bus_ack || expired) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Stall is combinational in IDLE so the pipeline freezes in the accept cycle.
  always_comb begin
    stall     = 1'b0;
    bus_req_c = 1'b0;
    case (state)
      ST_IDLE: stall = accept;
      ST_BUSY: begin
        stall     = 1'b1;
        bus_req_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latches, load result and error flag. An ack in the timeout cycle
  // takes priority, so the ack branch is tested first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      is_read_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          addr_q    <= address;
          wdata_q   <= write_data;
          we_q      <= mem_write;
          is_read_q <= !mem_write;
          error_q   <= !legal;
        end
        ST_BUSY: begin
          if (bus.bus_ack) begin
            if (is_read_q) rdata_q <= bus.bus_rdata;
            error_q <= 1'b0;
          end else if (expired) begin
            if (is_read_q) rdata_q <= '0;
            error_q <= 1'b1;
          end
        end
        ST_DONE: error_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.bus_req   = bus_req_c;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign read_data     = rdata_q;
  assign error         = error_q;
  assign state_dbg     = state;
endmodule
